dsram_req_ctrl: RTL and testbench

//  Data-SRAM request sequencer between the EX/MEM pipeline stages and an SRAM-like data port.

---
 rtl/dsram_req_ctrl_if.sv | 27 ++
 rtl/dsram_req_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dsram_req_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsram_req_ctrl_if.sv
// Data-SRAM port bundle between the request sequencer (master) and the SRAM-like slave.
interface dsram_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              data_sram_req;
  logic              data_sram_wr;
  logic [1:0]        data_sram_size;
  logic [3:0]        data_sram_wstrb;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic              data_sram_addr_ok;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/dsram_req_ctrl.sv
// Data-SRAM request sequencer: issues EX address phases, collects data phases for MEM,
// and swallows responses of ops killed by a pipeline flush (one live op at a time).
module dsram_req_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int CANCEL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [1:0]        ex_size_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_ready_go_o,
  input  logic              mem_fire_i,
  output logic              mem_ready_go_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  input  logic              excep_flush_i,
  dsram_req_ctrl_if.master  sram
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD} state_e;

  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic [CANCEL_W-1:0] cancel_q, cancel_d;
  logic                kill_q, kill_d;
  logic                lat_wr_q, lat_wr_d;
  logic [1:0]          lat_size_q, lat_size_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [3:0]          lat_wstrb_q, lat_wstrb_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [3:0]          ex_wstrb;
  logic [DATA_W-1:0]   ex_wdata_rep;
  logic                issue, inc, cancel_rsp, live_rsp;
  logic                req, wr;
  logic [1:0]          size;
  logic [3:0]          wstrb;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;

  always_comb begin
    case (ex_size_i)
      2'd0: begin
        ex_wstrb     = 4'b0001 << ex_addr_i[1:0];
        ex_wdata_rep = {4{ex_wdata_i[7:0]}};
      end
      2'd1: begin
        ex_wstrb     = 4'b0011 << {ex_addr_i[1], 1'b0};
        ex_wdata_rep = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        ex_wstrb     = 4'b1111;
        ex_wdata_rep = ex_wdata_i;
      end
    endcase
    if (!ex_we_i) ex_wstrb = '0;
  end

  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    kill_d      = kill_q;
    lat_wr_d    = lat_wr_q;
    lat_size_d  = lat_size_q;
    lat_addr_d  = lat_addr_q;
    lat_wstrb_d = lat_wstrb_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    issue          = 1'b0;
    inc            = 1'b0;
    ex_ready_go_o  = 1'b0;
    mem_ready_go_o = 1'b0;
    req            = 1'b0;

    // A data_ok with pending cancels always belongs to the oldest killed op.
    cancel_rsp  = sram.data_sram_data_ok && (cancel_q != '0);
    live_rsp    = (state_q == S_DATA) && sram.data_sram_data_ok && (cancel_q == '0);
    mem_rdata_o = live_rsp ? sram.data_sram_rdata : rdata_q;

    case (state_q)
      S_IDLE: begin
        issue = ex_req_i && !excep_flush_i && (cancel_q != CNT_MAX);
        req   = issue;
        if (issue) begin
          if (sram.data_sram_addr_ok) begin
            ex_ready_go_o = 1'b1;
            state_d       = S_DATA;
          end else begin
            lat_wr_d    = ex_we_i;
            lat_size_d  = ex_size_i;
            lat_addr_d  = ex_addr_i;
            lat_wstrb_d = ex_wstrb;
            lat_wdata_d = ex_wdata_rep;
            state_d     = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        req = 1'b1;
        if (sram.data_sram_addr_ok) begin
          if (kill_q || excep_flush_i) begin
            inc     = 1'b1;
            kill_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            ex_ready_go_o = 1'b1;
            state_d       = S_DATA;
          end
        end else if (excep_flush_i) begin
          kill_d = 1'b1;
        end
      end
      S_DATA: begin
        mem_ready_go_o = live_rsp;
        if (excep_flush_i) begin
          inc     = !live_rsp;
          state_d = S_IDLE;
        end else if (live_rsp) begin
          rdata_d = sram.data_sram_rdata;
          state_d = mem_fire_i ? S_IDLE : S_HOLD;
        end
      end
      default: begin
        mem_ready_go_o = 1'b1;
        if (excep_flush_i || mem_fire_i) state_d = S_IDLE;
      end
    endcase

    if (inc && !cancel_rsp)      cancel_d = cancel_q + CANCEL_W'(1);
    else if (!inc && cancel_rsp) cancel_d = cancel_q - CANCEL_W'(1);

    if (state_q == S_ADDR) begin
      wr = lat_wr_q; size = lat_size_q; addr = lat_addr_q;
      wstrb = lat_wstrb_q; wdata = lat_wdata_q;
    end else if (issue) begin
      wr = ex_we_i; size = ex_size_i; addr = ex_addr_i;
      wstrb = ex_wstrb; wdata = ex_wdata_rep;
    end else begin
      wr = 1'b0; size = '0; addr = '0; wstrb = '0; wdata = '0;
    end
  end

  assign sram.data_sram_req   = req;
  assign sram.data_sram_wr    = wr;
  assign sram.data_sram_size  = size;
  assign sram.data_sram_wstrb = wstrb;
  assign sram.data_sram_addr  = addr;
  assign sram.data_sram_wdata = wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cancel_q    <= '0;
      kill_q      <= 1'b0;
      lat_wr_q    <= 1'b0;
      lat_size_q  <= '0;
      lat_addr_q  <= '0;
      lat_wstrb_q <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      kill_q      <= kill_d;
      lat_wr_q    <= lat_wr_d;
      lat_size_q  <= lat_size_d;
      lat_addr_q  <= lat_addr_d;
      lat_wstrb_q <= lat_wstrb_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Bench for dsram_req_ctrl: directed vectors, an op-level reference model checked every cycle,
// and literal expectations at key points of each scenario.
module tb_dsram_req_ctrl;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_req, ex_we, mem_fire, flush;
  logic [1:0]    ex_size;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata, mem_rdata;
  logic          ex_ready_go, mem_ready_go;

  int checks = 0;
  int errors = 0;

  dsram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

  dsram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CANCEL_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ex_req_i(ex_req), .ex_we_i(ex_we), .ex_size_i(ex_size), .ex_addr_i(ex_addr),
    .ex_wdata_i(ex_wdata), .ex_ready_go_o(ex_ready_go),
    .mem_fire_i(mem_fire), .mem_ready_go_o(mem_ready_go), .mem_rdata_o(mem_rdata),
    .excep_flush_i(flush), .sram(sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte lanes covered by an access: naturally aligned block of 1/2/4 bytes containing addr.
  function automatic logic [3:0] f_strb(input logic we, input logic [1:0] sz, input logic [31:0] a);
    int nb, off;
    logic [3:0] s;
    s = '0;
    nb = (sz >= 2) ? 4 : (1 << sz);
    off = (int'(a[1:0]) / nb) * nb;
    for (int i = 0; i < 4; i++) if (we && i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] wd);
    int nb;
    logic [31:0] r;
    nb = (sz >= 2) ? 4 : (1 << sz);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    return r;
  endfunction

  // Op-level model: at most one op tracked, plus a count of killed ops still owing a response.
  bit          m_busy, m_adone, m_ddone, m_kill, m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wd, m_held;
  int          m_canc;

  always @(negedge clk) begin
    bit can_issue, exp_req, exp_rdy, exp_mrg, live, pend_addr, owes;
    logic        e_we;
    logic [1:0]  e_sz;
    logic [31:0] e_addr, e_wd, e_rd;
    if (rst) begin
      m_busy = 0; m_adone = 0; m_ddone = 0; m_kill = 0; m_we = 0;
      m_size = '0; m_addr = '0; m_wd = '0; m_held = '0; m_canc = 0;
    end else begin
      pend_addr = m_busy && !m_adone;
      can_issue = !m_busy && ex_req && !flush && (m_canc < MAXC);
      exp_req   = can_issue || pend_addr;
      if (pend_addr) begin
        e_we = m_we; e_sz = m_size; e_addr = m_addr; e_wd = m_wd;
      end else begin
        e_we = ex_we; e_sz = ex_size; e_addr = ex_addr; e_wd = ex_wdata;
      end
      exp_rdy = exp_req && sif.data_sram_addr_ok && !(pend_addr && (m_kill || flush));
      owes    = sif.data_sram_data_ok && (m_canc > 0);
      live    = m_busy && m_adone && !m_ddone && sif.data_sram_data_ok && (m_canc == 0);
      exp_mrg = live || (m_busy && m_ddone);
      e_rd    = live ? sif.data_sram_rdata : m_held;

      chk("req", sif.data_sram_req, exp_req);
      chk("ex_ready_go", ex_ready_go, exp_rdy);
      chk("mem_ready_go", mem_ready_go, exp_mrg);
      if (exp_mrg) chk("mem_rdata", mem_rdata, e_rd);
      if (exp_req) begin
        chk("wr", sif.data_sram_wr, e_we);
        chk("size", sif.data_sram_size, e_sz);
        chk("addr", sif.data_sram_addr, e_addr);
        chk("wstrb", sif.data_sram_wstrb, f_strb(e_we, e_sz, e_addr));
        chk("wdata", sif.data_sram_wdata, f_wd(e_sz, e_wd));
      end

      if (owes) m_canc--;
      if (can_issue) begin
        m_busy = 1; m_adone = sif.data_sram_addr_ok; m_ddone = 0; m_kill = 0;
        m_we = ex_we; m_size = ex_size; m_addr = ex_addr; m_wd = ex_wdata;
      end else if (pend_addr) begin
        if (sif.data_sram_addr_ok) begin
          if (m_kill || flush) begin m_canc++; m_busy = 0; end
          else m_adone = 1;
        end else if (flush) m_kill = 1;
      end else if (m_busy && !m_ddone) begin
        if (flush) begin
          if (!live) m_canc++;
          m_busy = 0;
        end else if (live) begin
          m_held = sif.data_sram_rdata;
          if (mem_fire) m_busy = 0; else m_ddone = 1;
        end
      end else if (m_busy) begin
        if (flush || mem_fire) m_busy = 0;
      end
    end
  end

  task automatic idle_in();
    ex_req = 0; ex_we = 0; ex_size = '0; ex_addr = '0; ex_wdata = '0;
    mem_fire = 0; flush = 0;
    sif.data_sram_addr_ok = 0; sif.data_sram_data_ok = 0; sif.data_sram_rdata = '0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic ok);
    ex_req = 1; ex_we = we; ex_size = sz; ex_addr = a; ex_wdata = wd;
    sif.data_sram_addr_ok = ok;
  endtask

  task automatic respond(input logic [31:0] rd, input logic fire);
    idle_in();
    sif.data_sram_data_ok = 1; sif.data_sram_rdata = rd; mem_fire = fire;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle_in();
    repeat (2) @(posedge clk);
    mid();
    chk("rst_ready", ex_ready_go, 0);
    chk("rst_mrg", mem_ready_go, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_req", sif.data_sram_req, 0);
    @(posedge clk); #1 rst = 0;

    // Load word, address accepted immediately, data next cycle.
    drive(0, 2, 32'h1000, 0, 1);
    mid(); chk("t1_req", sif.data_sram_req, 1); chk("t1_ready", ex_ready_go, 1);
    chk("t1_addr", sif.data_sram_addr, 32'h1000); chk("t1_wstrb", sif.data_sram_wstrb, 0);
    adv(); respond(32'hDEADBEEF, 1);
    mid(); chk("t1_mrg", mem_ready_go, 1); chk("t1_rdata", mem_rdata, 32'hDEADBEEF);
    adv(); idle_in();
    mid(); chk("t1_idle_mrg", mem_ready_go, 0);
    adv();

    // Byte and half stores: strobes and lane replication.
    drive(1, 0, 32'h1003, 32'h5A, 1);
    mid(); chk("sb_wstrb", sif.data_sram_wstrb, 4'b1000);
    chk("sb_wdata", sif.data_sram_wdata, 32'h5A5A5A5A); chk("sb_wr", sif.data_sram_wr, 1);
    adv(); respond(0, 1); mid(); adv();
    drive(1, 1, 32'h1002, 32'h1234, 1);
    mid(); chk("sh_wstrb", sif.data_sram_wstrb, 4'b1100);
    chk("sh_wdata", sif.data_sram_wdata, 32'h12341234);
    adv(); respond(0, 1); mid(); adv(); idle_in();

    // Address phase stalled three cycles while EX fields change.
    drive(1, 2, 32'h2000, 32'hCAFEF00D, 0);
    mid(); chk("t3_req0", sif.data_sram_req, 1); chk("t3_ready0", ex_ready_go, 0);
    adv();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 32'h3001, 0, 0);
      mid();
      chk("t3_req", sif.data_sram_req, 1); chk("t3_addr", sif.data_sram_addr, 32'h2000);
      chk("t3_wr", sif.data_sram_wr, 1); chk("t3_wstrb", sif.data_sram_wstrb, 4'b1111);
      chk("t3_wdata", sif.data_sram_wdata, 32'hCAFEF00D); chk("t3_ready", ex_ready_go, 0);
      adv();
    end
    sif.data_sram_addr_ok = 1;
    mid(); chk("t3_ready3", ex_ready_go, 1); chk("t3_addr3", sif.data_sram_addr, 32'h2000);
    adv(); respond(0, 1); mid(); adv(); idle_in();

    // Flush in DATA, new load, stale response dropped before the live one.
    drive(0, 2, 32'h4000, 0, 1); mid(); adv();
    idle_in(); flush = 1; mid(); adv();
    idle_in(); drive(0, 2, 32'h5000, 0, 1);
    mid(); chk("t4_ready", ex_ready_go, 1); adv();
    respond(32'h1111, 1); mid(); chk("t4_drop_mrg", mem_ready_go, 0); adv();
    respond(32'h2222, 1); mid(); chk("t4_mrg", mem_ready_go, 1);
    chk("t4_rdata", mem_rdata, 32'h2222); adv(); idle_in();

    // MEM stalled: data held, then flushed out of HOLD.
    drive(0, 2, 32'h6000, 0, 1); mid(); adv();
    respond(32'hA5A50F0F, 0); mid(); chk("t5_mrg0", mem_ready_go, 1);
    chk("t5_rd0", mem_rdata, 32'hA5A50F0F); adv(); idle_in();
    for (int k = 0; k < 2; k++) begin
      mid(); chk("t5_hold_mrg", mem_ready_go, 1); chk("t5_hold_rd", mem_rdata, 32'hA5A50F0F);
      adv();
    end
    flush = 1; mid(); chk("t5_flush_mrg", mem_ready_go, 1); adv();
    idle_in(); mid(); chk("t5_after_mrg", mem_ready_go, 0); adv();

    // Saturate the cancel counter: issue blocked until a stale response drains one.
    for (int k = 0; k < 3; k++) begin
      drive(0, 2, 32'h7000, 0, 1); mid(); adv();
      idle_in(); flush = 1; mid(); adv(); idle_in();
    end
    drive(0, 2, 32'h7000, 0, 1);
    mid(); chk("t6_blk_req", sif.data_sram_req, 0); chk("t6_blk_ready", ex_ready_go, 0); adv();
    sif.data_sram_addr_ok = 0; sif.data_sram_data_ok = 1; sif.data_sram_rdata = 32'hEEEE;
    mid(); chk("t6_blk_req2", sif.data_sram_req, 0); chk("t6_blk_mrg", mem_ready_go, 0); adv();
    sif.data_sram_data_ok = 0; sif.data_sram_addr_ok = 1;
    mid(); chk("t6_req", sif.data_sram_req, 1); chk("t6_ready", ex_ready_go, 1); adv();
    for (int k = 0; k < 2; k++) begin
      respond(32'h100 + k, 1); mid(); chk("t6_stale_mrg", mem_ready_go, 0); adv();
    end
    respond(32'h7777, 1); mid(); chk("t6_mrg", mem_ready_go, 1);
    chk("t6_rdata", mem_rdata, 32'h7777); adv(); idle_in();

    // Flush while the address phase is stalled: request held, op killed on addr_ok.
    drive(0, 2, 32'h8000, 0, 0); mid(); adv();
    idle_in(); flush = 1;
    mid(); chk("t7_req_held", sif.data_sram_req, 1); chk("t7_addr", sif.data_sram_addr, 32'h8000);
    adv(); idle_in(); sif.data_sram_addr_ok = 1;
    mid(); chk("t7_req", sif.data_sram_req, 1); chk("t7_ready", ex_ready_go, 0); adv();
    respond(32'h0BAD, 1); mid(); chk("t7_stale_mrg", mem_ready_go, 0); adv(); idle_in();

    // Reset with a pending cancel: it is forgotten.
    drive(0, 2, 32'h8800, 0, 1); mid(); adv();
    idle_in(); flush = 1; mid(); adv();
    idle_in(); rst = 1;
    mid(); chk("t8_rst_rdata", mem_rdata, 0); chk("t8_rst_mrg", mem_ready_go, 0); adv();
    rst = 0; drive(0, 2, 32'h9000, 0, 1);
    mid(); chk("t8_ready", ex_ready_go, 1); adv();
    respond(32'h9999, 1); mid(); chk("t8_mrg", mem_ready_go, 1);
    chk("t8_rdata", mem_rdata, 32'h9999); adv(); idle_in();

    // Sweep sizes and offsets for stores and loads.
    for (int s = 0; s < 3; s++) begin
      for (int o = 0; o < 4; o++) begin
        drive(1'((s + o) % 2 == 0), 2'(s), 32'h100 + 32'(o), 32'hA1B2C3D4 + 32'(s * 16 + o), 1);
        mid(); adv();
        respond(32'h5500 + 32'(o), 1); mid(); adv(); idle_in();
      end
    end
    mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
